// File: rtl/alu_pkg.sv
// Shared ALU control codes, FSM encoding and datapath width for the EX-stage
// execution unit and the ALU control decoder.
package alu_pkg;
    localparam int DATA_W = 32;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_LW   = 4'd2;
    localparam logic [3:0] ALU_SW   = 4'd3;
    localparam logic [3:0] ALU_ADDU = 4'd4;
    localparam logic [3:0] ALU_SUBU = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_BLEZ = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SRAV = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;
    localparam logic [3:0] ALU_SLTU = 4'd11;
    localparam logic [3:0] ALU_SLL  = 4'd12;
    localparam logic [3:0] ALU_SMUL = 4'd13;
    localparam logic [3:0] ALU_BGTZ = 4'd14;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;
endpackage

// File: rtl/alu_seq_exec_if.sv
// Request/response bundle between the EX pipeline stage and alu_seq_exec.
interface alu_seq_exec_if;
    import alu_pkg::*;

    logic              start_i;
    logic [3:0]        ctrl_i;
    logic [DATA_W-1:0] src1_i;
    logic [DATA_W-1:0] src2_i;
    logic [DATA_W-1:0] result_o;
    logic              zero_o;
    logic              busy_o;
    logic              done_o;

    modport master (
        output start_i, ctrl_i, src1_i, src2_i,
        input  result_o, zero_o, busy_o, done_o
    );

    modport slave (
        input  start_i, ctrl_i, src1_i, src2_i,
        output result_o, zero_o, busy_o, done_o
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per step, 32 steps.
// Only the low word is kept, which is the same for signed and unsigned operands.
module alu_mul_seq
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              step,
    output logic [DATA_W-1:0] acc,
    output logic              last
);
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc_q;
    logic [5:0]        cnt;

    // acc already includes this step's partial product, so the caller can
    // capture the final product on the same edge that retires the last step.
    assign acc  = acc_q + (mplier[0] ? mcand : '0);
    assign last = (cnt == 6'd31);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc_q  <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= src1;
            mplier <= src2;
            acc_q  <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc_q  <= acc;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 6'd1;
        end
    end
endmodule

// File: rtl/alu_seq_exec.sv
// EX-stage execution unit: single-cycle ALU ops plus a 32-cycle sequential SMUL
// behind a start/busy/done handshake.
module alu_seq_exec
    import alu_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    alu_seq_exec_if.slave    bus
);
    state_t            state;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic              done_q;

    logic [DATA_W-1:0] res_c;
    logic              zero_c;
    logic [DATA_W-1:0] diff;
    logic [4:0]        shamt;

    logic              mul_load;
    logic              mul_step;
    logic [DATA_W-1:0] mul_acc;
    logic              mul_last;

    assign diff  = bus.src1_i - bus.src2_i;
    assign shamt = bus.src1_i[4:0];

    always_comb begin
        res_c  = '0;
        zero_c = 1'b0;
        unique case (bus.ctrl_i)
            ALU_AND:                   res_c = bus.src1_i & bus.src2_i;
            ALU_OR:                    res_c = bus.src1_i | bus.src2_i;
            ALU_LW, ALU_SW, ALU_ADDU:  res_c = bus.src1_i + bus.src2_i;
            ALU_SUBU, ALU_BLEZ,
            ALU_BGTZ:                  res_c = diff;
            ALU_SLT:  res_c = {{(DATA_W-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
            ALU_SLTU: res_c = {{(DATA_W-1){1'b0}}, (bus.src1_i < bus.src2_i)};
            ALU_SRA, ALU_SRAV:         res_c = $signed(bus.src2_i) >>> shamt;
            ALU_SLL:                   res_c = bus.src2_i << shamt;
            ALU_LUI:                   res_c = {bus.src2_i[15:0], 16'b0};
            default:                   res_c = '0;
        endcase
        // Branch tests look only at src1's sign; code 15 never flags zero.
        if (bus.ctrl_i == ALU_BLEZ)
            zero_c = bus.src1_i[DATA_W-1] || (bus.src1_i == '0);
        else if (bus.ctrl_i == ALU_BGTZ)
            zero_c = !bus.src1_i[DATA_W-1] && (bus.src1_i != '0);
        else if (bus.ctrl_i == 4'd15)
            zero_c = 1'b0;
        else
            zero_c = (res_c == '0);
    end

    assign mul_load = (state == ST_IDLE) && bus.start_i && (bus.ctrl_i == ALU_SMUL);
    assign mul_step = (state == ST_MUL);

    alu_mul_seq u_mul (
        .clk  (clk_i),
        .rst  (rst_i),
        .load (mul_load),
        .src1 (bus.src1_i),
        .src2 (bus.src2_i),
        .step (mul_step),
        .acc  (mul_acc),
        .last (mul_last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        if (bus.ctrl_i == ALU_SMUL) begin
                            state <= ST_MUL;
                        end else begin
                            result_q <= res_c;
                            zero_q   <= zero_c;
                            done_q   <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_last) begin
                        result_q <= mul_acc;
                        zero_q   <= (mul_acc == '0);
                        done_q   <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.result_o = result_q;
    assign bus.zero_o   = zero_q;
    assign bus.done_o   = done_q;
    assign bus.busy_o   = (state == ST_MUL);
endmodule

// File: doc/alu_seq_exec.md
# alu_seq_exec

Multi-cycle execution unit consuming the 4-bit ALU control code produced by the ALU control decoder in the EX stage. Single-cycle ops (logic, add/sub, compares, shifts, LUI, branch tests) complete in one clock. Signed multiply (SMUL) runs as a 32-iteration shift-add sequence. A start/busy/done handshake lets the pipeline stall while the multiply is in flight.

## Interface
- DATA_W, 32, operand/result width; 32 is the only supported value.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  request; sampled only in IDLE.
- ctrl_i  in  4  ALU control code.
- src1_i  in  32  operand 1; holds the shift amount for SRA/SLL.
- src2_i  in  32  operand 2.
- result_o  out  32  registered result; holds until the next completion.
- zero_o  out  1  registered branch/zero flag.
- busy_o  out  1  high while in MUL state.
- done_o  out  1  one-cycle completion pulse.

## Operation
- Control codes (AND=0, OR=1, LW=2, SW=3, ADDU=4, SUBU=5, SLT=6, BLEZ=7, SRA=8, SRAV=9, LUI=10, SLTU=11, SLL=12, SMUL=13, BGTZ=14):
  - AND / OR: src1&src2 / src1|src2.
  - LW, SW, ADDU: src1+src2, mod 2^32.
  - SUBU: src1-src2, mod 2^32.
  - SLT: {31'b0, $signed(src1)<$signed(src2)}.
  - SLTU: the same compare, unsigned.
  - SRA, SRAV: $signed(src2)>>>src1[4:0].
  - SLL: src2<<src1[4:0].
  - LUI: {src2[15:0],16'b0}.
  - BLEZ: result = src1-src2.
  - BGTZ: result = src1-src2.
  - SMUL: low 32 bits of src1*src2. These are identical for signed and unsigned, so an unsigned shift-add is used; the high word is discarded.
  - Code 15: result 0, zero_o 0.
- zero_o:
  - BLEZ: 1 iff $signed(src1)<=0.
  - BGTZ: 1 iff $signed(src1)>0.
  - All other codes: 1 iff the result is 0.
- FSM: IDLE, MUL.
  - IDLE, start_i=1, ctrl_i≠SMUL: compute, register result_o/zero_o, assert done_o, stay in IDLE.
  - IDLE, start_i=1, ctrl_i=SMUL: latch multiplicand=src1, multiplier=src2; clear acc and cnt; go to MUL.
  - MUL, each edge: if multiplier[0], acc += multiplicand; then multiplicand <<= 1, multiplier >>= 1, cnt++.
  - MUL, edge where cnt reaches 31→32: write the final acc to result_o, update zero_o, pulse done_o, return to IDLE.
- start_i and operand changes during MUL are ignored; the operands are latched.
- Reset:
  - State IDLE.
  - result_o=0, zero_o=0, done_o=0, busy_o=0.
  - cnt, acc and operand registers are 0.
  - Reset mid-multiply aborts it; no done_o is produced.

## Timing
- Single-cycle op: start sampled at edge N → result_o, zero_o and done_o are valid after edge N. done_o is high for exactly one cycle.
- SMUL: start sampled at edge N.
  - busy_o=1 after edge N through edge N+32.
  - result_o, zero_o and done_o are updated at edge N+32.
  - busy_o=0 in the same cycle that done_o=1.
  - Latency is 32 cycles from acceptance.
- Back-to-back: a new start is accepted in the cycle where done_o=1, with no bubble.
- busy_o is decoded combinationally from the state register. All other outputs are registered.
- result_o and zero_o keep their value when idle.

## Structure
- Package alu_pkg:
  - the ALU control code localparams above (shared with the ALU control decoder);
  - the FSM state encoding;
  - DATA_W.
- Sub-module alu_mul_seq: iterative shift-add multiplier, interfaced by load/operands/step/acc/last. The top level holds the FSM, the combinational single-cycle datapath and the output registers.

## Test plan
- ADDU 0x7FFFFFFF + 0x00000001, start 1 cycle → result 0x80000000, zero 0, done pulse 1 cycle later.
- SUBU 5 - 5 → result 0, zero 1. BLEZ with src1=0xFFFFFFFF → zero 1. BGTZ with src1=0 → zero 0.
- SRA with src1=4, src2=0xF0000000 → 0xFF000000. SLL with src1=31, src2=3 → 0x80000000. LUI with src2=0x1234 → 0x12340000.
- SMUL 0xFFFFFFFD (-3) × 7:
  - busy for 32 cycles;
  - result 0xFFFFFFEB at edge N+32, done pulse;
  - start pulses and operand changes during busy have no effect.
- SMUL followed immediately by ADDU 2+3, issued in the done cycle → ADDU done one cycle later with result 5, no stall.
- Assert rst_i mid-SMUL (cycle 10):
  - outputs are 0 immediately (asynchronous);
  - no done_o follows;
  - a subsequent SMUL 6×7 returns 42.
